// File: rtl/key_pkg.sv
// Shared constants and sizing helper for the front-panel key debouncer.
package key_pkg;

  localparam int DEBOUNCE_CYCLES_20MS = 1_000_000;
  localparam int LONG_CYCLES_1S       = 50_000_000;

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, restart-on-change stability counter,
// hold counter, and registered press/release/long-press pulses.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_20MS,
  parameter int LONG_CYCLES     = LONG_CYCLES_1S,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic press_next_o
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int LW = cnt_width(LONG_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
  localparam logic RELEASED = (ACTIVE_LOW != 0);

  logic          sync1_q, sync2_q, p;
  logic          state_q, state_d;
  logic          press_q, press_d, release_q, release_d, long_q, long_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [LW-1:0] hold_q, hold_d;

  assign p = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    if (p == state_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d  = '0;
      state_d   = p;
      press_d   = p;
      release_d = ~p;
    end else begin
      db_cnt_d = db_cnt_q + DW'(1);
    end

    // A release accepted on the threshold cycle wins over long_press.
    if (!state_q || release_d) begin
      hold_d = '0;
    end else if (hold_q == LONG_LAST) begin
      hold_d = LONG_MAX;
      long_d = 1'b1;
    end else if (hold_q != LONG_MAX) begin
      hold_d = hold_q + LW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= RELEASED;
      sync2_q   <= RELEASED;
      state_q   <= 1'b0;
      db_cnt_q  <= '0;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign state_o      = state_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_o       = long_q;
  assign press_next_o = press_d;

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel key debouncer with a lowest-index press encoder registered
// alongside the per-channel press pulses.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_20MS,
  parameter int LONG_CYCLES     = LONG_CYCLES_1S,
  parameter int ACTIVE_LOW      = 1,
  localparam int IW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] long_press,
  output logic              press_any,
  output logic [IW-1:0]     press_idx
);

  logic [N_KEYS-1:0] press_nx;
  logic              press_any_q;
  logic [IW-1:0]     press_idx_q, press_idx_d;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .key_i       (key[gi]),
      .state_o     (key_state[gi]),
      .press_o     (key_press[gi]),
      .release_o   (key_release[gi]),
      .long_o      (long_press[gi]),
      .press_next_o(press_nx[gi])
    );
  end

  // Scan high to low so the lowest set index is the one left standing.
  always_comb begin
    press_idx_d = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (press_nx[i]) press_idx_d = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_any_q <= 1'b0;
      press_idx_q <= '0;
    end else begin
      press_any_q <= |press_nx;
      press_idx_q <= press_idx_d;
    end
  end

  assign press_any = press_any_q;
  assign press_idx = press_idx_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_key_debounce_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] key_state, key_press, key_release, long_press;
  logic       press_any;
  logic [1:0] press_idx;

  int n_cmp = 0;
  int n_bad = 0;

  key_debounce_multi #(
    .N_KEYS         (4),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .long_press (long_press),
    .press_any  (press_any),
    .press_idx  (press_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {13'd0, key_state, key_press, key_release, long_press, press_any, press_idx}, 32'd0);
  endtask

  // n-1 quiet cycles, then the n-th cycle must show exactly the given pulses.
  task automatic expect_event(input string tag, input int n,
                              input logic [3:0] e_press, input logic [3:0] e_rel,
                              input logic [3:0] e_long);
    for (int i = 1; i < n; i++) begin
      step();
      chk({tag, "_quiet"}, {key_press, key_release, long_press, press_any}, 32'd0);
    end
    step();
    chk({tag, "_press"}, key_press, e_press);
    chk({tag, "_release"}, key_release, e_rel);
    chk({tag, "_long"}, long_press, e_long);
    chk({tag, "_any"}, press_any, (e_press != 4'd0));
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 4'hF;

    // 1: reset, no stray pulses after deassertion
    #1;
    chk_all_zero("t1_reset");
    repeat (5) step();
    chk_all_zero("t1_in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all_zero("t1_post_reset");
    end

    // 2: key0 press at edge 6, then release 6 edges later, no long press
    key[0] = 1'b0;
    expect_event("t2_press", 6, 4'b0001, 4'b0000, 4'b0000);
    chk("t2_idx", press_idx, 2'd0);
    chk("t2_state", key_state, 4'b0001);
    key[0] = 1'b1;
    expect_event("t2_rel", 6, 4'b0000, 4'b0001, 4'b0000);
    chk("t2_state_rel", key_state, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t2_no_long", {key_press, key_release, long_press}, 32'd0);
    end

    // 3: bounce on key1, then a single clean press
    for (int r = 0; r < 5; r++) begin
      key[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step();
        chk("t3_bounce", {key_state, key_press, key_release, long_press}, 32'd0);
      end
      key[1] = 1'b1;
      step();
      chk("t3_bounce", {key_state, key_press, key_release, long_press}, 32'd0);
    end
    key[1] = 1'b0;
    expect_event("t3_press", 6, 4'b0010, 4'b0000, 4'b0000);
    chk("t3_idx", press_idx, 2'd1);
    key[1] = 1'b1;
    expect_event("t3_rel", 6, 4'b0000, 4'b0010, 4'b0000);

    // 4: long press on key2 fires once at press+10
    key[2] = 1'b0;
    expect_event("t4_press", 6, 4'b0100, 4'b0000, 4'b0000);
    chk("t4_idx", press_idx, 2'd2);
    expect_event("t4_long", 10, 4'b0000, 4'b0000, 4'b0100);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t4_no_repeat", {key_press, key_release, long_press}, 32'd0);
    end
    chk("t4_state_held", key_state, 4'b0100);
    key[2] = 1'b1;
    expect_event("t4_rel", 6, 4'b0000, 4'b0100, 4'b0000);
    chk("t4_state_rel", key_state, 4'b0000);

    // 5: simultaneous presses on key1 and key3
    key[1] = 1'b0;
    key[3] = 1'b0;
    expect_event("t5_press", 6, 4'b1010, 4'b0000, 4'b0000);
    chk("t5_idx", press_idx, 2'd1);
    chk("t5_state", key_state, 4'b1010);
    key[1] = 1'b1;
    key[3] = 1'b1;
    expect_event("t5_rel", 6, 4'b0000, 4'b1010, 4'b0000);

    // 6: reset mid-hold, key re-detected as a fresh press
    key[0] = 1'b0;
    expect_event("t6_press", 6, 4'b0001, 4'b0000, 4'b0000);
    repeat (3) step();
    chk("t6_state_before", key_state, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async_clear");
    repeat (3) step();
    chk_all_zero("t6_in_reset");
    rst_n = 1'b1;
    expect_event("t6_repress", 6, 4'b0001, 4'b0000, 4'b0000);
    chk("t6_idx", press_idx, 2'd0);
    expect_event("t6_long", 10, 4'b0000, 4'b0000, 4'b0001);
    key[0] = 1'b1;
    expect_event("t6_rel", 6, 4'b0000, 4'b0001, 4'b0000);
    chk("t6_state_end", key_state, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
